// File: rtl/ahb_slave_regfile.sv
// ---------------------------------------------------------------------------
// ahb_slave_regfile
//   Register-file back end for the AHB slave path. Consumes data-phase beats
//   from the slave controller and answers each beat combinationally with
//   read data, an error flag and a burst-done flag. Writes land one cycle
//   after their beat, when the controller presents the registered write data.
//
//   Map: reg 0 ID (RO), reg 1 STATUS (RO), regs 2..NUM_REGS-1 RW.
//
// Ports
//   HCLK, HRESETn    clock, async active-low reset
//   addr, size       beat byte address and transfer size
//   burst            HBURST encoding of the current transfer
//   prot, mastlock   protection (prot[1] = privileged), locked flag
//   strb             byte-lane strobe (0 = use the size/address lane mask)
//   write_data       write data, valid the cycle after its beat
//   write_read       1 = write, 0 = read
//   transfer_valid   one beat per high cycle
//   read_data        read data (0 unless a legal read beat)
//   burst_done       last beat of a SINGLE or fixed-length burst
//   error_flag       current beat is illegal
// ---------------------------------------------------------------------------
module ahb_slave_regfile #(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'hA4B0_0001
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [2:0]  burst,
    input  logic [3:0]  prot,
    input  logic        mastlock,
    input  logic [3:0]  strb,
    input  logic [31:0] write_data,
    input  logic        write_read,
    input  logic        transfer_valid,
    output logic [31:0] read_data,
    output logic        burst_done,
    output logic        error_flag
);
    localparam int unsigned IW = $clog2(NUM_REGS);

    // Write accepted in the previous beat, waiting for its data.
    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
        logic [3:0]    lanes;
    } pend_t;

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    pend_t       pend_q, pend_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  wr_cnt_q, wr_cnt_d;
    logic        mlock_q, mlock_d;

    logic [31:0]   off;
    logic [IW-1:0] idx;
    logic          out_rng, bad_size, misalign, ro_write, priv_viol, legal;
    logic [3:0]    size_mask, lane_mask, lanes;
    logic          fixed_len;
    logic [3:0]    last_beat;
    logic [31:0]   status, rd_base, rd_fwd;
    logic          unused_prot;

    assign unused_prot = ^{prot[3:2], prot[0]};

    // ---------------- beat decode ----------------
    always_comb begin
        off       = addr - BASE_ADDR;
        idx       = off[IW+1:2];
        // Range test uses the full offset so wrapped/high addresses never alias.
        out_rng   = (addr < BASE_ADDR) || ((off >> 2) >= 32'(NUM_REGS));
        bad_size  = (size > 3'b010);
        misalign  = ((size == 3'b001) && addr[0]) ||
                    ((size == 3'b010) && (addr[1:0] != 2'b00));
        ro_write  = write_read && (idx < IW'(2));
        priv_viol = !prot[1] && (idx >= IW'(NUM_REGS / 2));
        error_flag = transfer_valid &&
                     (out_rng || bad_size || misalign || ro_write || priv_viol);
        legal     = transfer_valid && !error_flag;
    end

    always_comb begin
        case (size)
            3'b000:  size_mask = 4'b0001;
            3'b001:  size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lane_mask = size_mask << addr[1:0];
        lanes     = (strb == 4'b0000) ? lane_mask : (lane_mask & strb);
    end

    // ---------------- burst tracking ----------------
    always_comb begin
        fixed_len = 1'b1;
        last_beat = 4'd0;
        case (burst)
            3'b010, 3'b011: last_beat = 4'd3;
            3'b100, 3'b101: last_beat = 4'd7;
            3'b110, 3'b111: last_beat = 4'd15;
            default:        fixed_len = 1'b0;   // SINGLE and INCR
        endcase
        burst_done = legal &&
                     ((burst == 3'b000) || (fixed_len && (beat_cnt_q == last_beat)));
        beat_cnt_d = (legal && !burst_done) ? beat_cnt_q + 4'd1 : 4'd0;
    end

    // ---------------- read path ----------------
    always_comb begin
        status = {15'd0, mlock_q, wr_cnt_q, err_cnt_q};
        if (idx == IW'(0))
            rd_base = ID_VALUE;
        else if (idx == IW'(1))
            rd_base = status;
        else
            rd_base = regs_q[idx];
        // A write still waiting for its commit edge is visible to reads now.
        rd_fwd = rd_base;
        for (int b = 0; b < 4; b++) begin
            if (pend_q.vld && (pend_q.idx == idx) && pend_q.lanes[b])
                rd_fwd[8*b +: 8] = write_data[8*b +: 8];
        end
        read_data = (legal && !write_read) ? rd_fwd : 32'd0;
    end

    // ---------------- next state ----------------
    always_comb begin
        regs_d = regs_q;
        if (pend_q.vld) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_q.lanes[b])
                    regs_d[pend_q.idx][8*b +: 8] = write_data[8*b +: 8];
            end
        end
        pend_d.vld   = legal && write_read;
        pend_d.idx   = idx;
        pend_d.lanes = lanes;
        wr_cnt_d     = wr_cnt_q + {7'd0, pend_q.vld};
        err_cnt_d    = (error_flag && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
        mlock_d      = transfer_valid ? mastlock : mlock_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'd0;
            pend_q     <= '0;
            beat_cnt_q <= 4'd0;
            err_cnt_q  <= 8'd0;
            wr_cnt_q   <= 8'd0;
            mlock_q    <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            mlock_q    <= mlock_d;
        end
    end

endmodule
